// File: rtl/gcm_ghash_ctrl.sv
// AES-GCM GHASH sequencer: clears the core, pads and forwards AAD/CT beats, appends the length block and captures S.
// Optional AAD-after-CT ordering check enabled by defining GCM_GHASH_CTRL_ORDER_CHECK_EN.
module gcm_ghash_ctrl #(
  parameter int LEN_W = 39
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         finish,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_is_aad,
  input  logic [4:0]   in_bytes,
  output logic         ghash_start,
  output logic [127:0] ghash_data,
  output logic         ghash_valid,
  input  logic         ghash_ready,
  input  logic [127:0] ghash_hash,
  output logic [127:0] s_out,
  output logic         done,
  output logic         busy,
  output logic         err
);

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_AAD, S_CT, S_LEN, S_WAIT} state_t;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] aad_len, ct_len, aad_len_nxt, ct_len_nxt;
  logic             capture;
  logic             beat_fire;
  logic [7:0]       beat_bits;

  // 0 and anything above 16 mean a full beat
  function automatic logic [4:0] beat_bytes(input logic [4:0] n);
    return (n == 5'd0 || n > 5'd16) ? 5'd16 : n;
  endfunction

  function automatic logic [127:0] pad_beat(input logic [127:0] d, input logic [4:0] n);
    logic [127:0] keep;
    keep = ~({128{1'b1}} >> {n, 3'b000});
    return d & keep;
  endfunction

  assign beat_bits = {beat_bytes(in_bytes), 3'b000};
  assign beat_fire = in_valid && in_ready;
  assign busy      = (state != S_IDLE);

`ifdef GCM_GHASH_CTRL_ORDER_CHECK_EN
  logic err_set;
`endif

  always_comb begin
    state_nxt   = state;
    in_ready    = 1'b0;
    ghash_start = 1'b0;
    ghash_valid = 1'b0;
    ghash_data  = '0;
    aad_len_nxt = aad_len;
    ct_len_nxt  = ct_len;
    capture     = 1'b0;
`ifdef GCM_GHASH_CTRL_ORDER_CHECK_EN
    err_set     = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_CLR;
      end
      S_CLR: begin
        ghash_start = 1'b1;
        aad_len_nxt = '0;
        ct_len_nxt  = '0;
        state_nxt   = S_AAD;
      end
      S_AAD, S_CT: begin
        in_ready   = ghash_ready && !start;
        ghash_data = pad_beat(in_data, beat_bytes(in_bytes));
        if (beat_fire) begin
          if (in_is_aad && state == S_AAD) begin
            ghash_valid = 1'b1;
            aad_len_nxt = aad_len + LEN_W'(beat_bits);
          end else if (in_is_aad) begin
`ifdef GCM_GHASH_CTRL_ORDER_CHECK_EN
            err_set     = 1'b1;
`else
            ghash_valid = 1'b1;
            ct_len_nxt  = ct_len + LEN_W'(beat_bits);
`endif
          end else begin
            ghash_valid = 1'b1;
            ct_len_nxt  = ct_len + LEN_W'(beat_bits);
            state_nxt   = S_CT;
          end
        end
        if (finish) state_nxt = S_LEN;
      end
      S_LEN: begin
        ghash_data = {64'(aad_len), 64'(ct_len)};
        if (!start && ghash_ready) begin
          ghash_valid = 1'b1;
          state_nxt   = S_WAIT;
        end
      end
      S_WAIT: begin
        capture   = !start;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // abort wins over everything else in any active state
    if (start && state != S_IDLE) state_nxt = S_CLR;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      aad_len <= '0;
      ct_len  <= '0;
      s_out   <= '0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      aad_len <= aad_len_nxt;
      ct_len  <= ct_len_nxt;
      done    <= capture;
      if (capture) s_out <= ghash_hash;
    end
  end

`ifdef GCM_GHASH_CTRL_ORDER_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               err <= 1'b0;
    else if (state == S_CLR) err <= 1'b0;
    else if (err_set)        err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gcm_ghash_ctrl.sv
// Bench for gcm_ghash_ctrl: directed messages, a stub GHASH core, and a message-level model checked every cycle.
module tb_gcm_ghash_ctrl;
  localparam int LEN_W = 39;

  logic         clk = 1'b0;
  logic         reset;
  logic         start, finish, in_valid, in_ready, in_is_aad;
  logic [127:0] in_data;
  logic [4:0]   in_bytes;
  logic         ghash_start, ghash_valid, ghash_ready;
  logic [127:0] ghash_data, ghash_hash, s_out;
  logic         done, busy, err;

  gcm_ghash_ctrl #(.LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_is_aad(in_is_aad), .in_bytes(in_bytes),
    .ghash_start(ghash_start), .ghash_data(ghash_data), .ghash_valid(ghash_valid),
    .ghash_ready(ghash_ready), .ghash_hash(ghash_hash),
    .s_out(s_out), .done(done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [127:0] data; bit is_len; } beat_t;

  int           tests = 0, fails = 0;
  int           cyc = 0, len_cyc = -100;
  beat_t        exp_q[$];
  beat_t        b_cur;
  logic [127:0] exp_s_q[$];
  logic [127:0] msg_beats[$];
  longint       m_aad_bits, m_ct_bits;
  bit           m_in_ct;
  logic [127:0] last_beat, last_len, acc, s_prev;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // stand-in for the GHASH core: any order-sensitive accumulator will do
  function automatic logic [127:0] core_step(input logic [127:0] a, input logic [127:0] d);
    return {a[126:0], a[127]} ^ d;
  endfunction

  always_ff @(posedge clk or posedge reset)
    if (reset)                           acc <= '0;
    else if (ghash_start)                acc <= '0;
    else if (ghash_valid && ghash_ready) acc <= core_step(acc, ghash_data);
  assign ghash_hash = acc;

  function automatic int eff_bytes(input int n);
    return (n == 0 || n > 16) ? 16 : n;
  endfunction

  function automatic logic [127:0] model_mask(input logic [127:0] d, input int n);
    logic [127:0] r = '0;
    for (int i = 0; i < eff_bytes(n); i++) r[127-8*i -: 8] = d[127-8*i -: 8];
    return r;
  endfunction

  // every-cycle checker against the model queues
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      if (ghash_start) check("start_with_valid", 128'(ghash_valid), 128'd0);
      if (ghash_valid) begin
        check("valid_without_ready", 128'(ghash_ready), 128'd1);
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_beat: got %h expected none", ghash_data);
        end else begin
          b_cur = exp_q.pop_front();
          check(b_cur.is_len ? "len_beat" : "data_beat", ghash_data, b_cur.data);
          if (b_cur.is_len) begin len_cyc = cyc; last_len = ghash_data; end
          else last_beat = ghash_data;
        end
      end
      if (done) begin
        check("done_latency", 128'(cyc - len_cyc), 128'd2);
        if (exp_s_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done: got s_out %h expected no done", s_out);
        end else check("s_out", s_out, exp_s_q.pop_front());
      end
    end
  end

  task automatic do_start();
    exp_q.delete(); msg_beats.delete();
    m_aad_bits = 0; m_ct_bits = 0; m_in_ct = 0;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("clr_ghash_start", 128'(ghash_start), 128'd1);
    @(posedge clk); #1;
  endtask

  task automatic model_finish();
    logic [127:0] lb;
    logic [127:0] s = '0;
    longint       lim = longint'(1) << LEN_W;
    lb = {64'(m_aad_bits % lim), 64'(m_ct_bits % lim)};
    exp_q.push_back('{lb, 1'b1});
    msg_beats.push_back(lb);
    foreach (msg_beats[i]) s = core_step(s, msg_beats[i]);
    exp_s_q.push_back(s);
  endtask

  task automatic send_beat(input logic [127:0] d, input int n, input bit aad, input bit fin);
    bit fwd = 1'b1;
    bit ok = 1'b0;
    in_valid = 1'b1; in_data = d; in_bytes = 5'(n); in_is_aad = aad; finish = fin;
    if (aad && !m_in_ct) m_aad_bits += 8 * eff_bytes(n);
    else if (aad) begin
`ifdef GCM_GHASH_CTRL_ORDER_CHECK_EN
      fwd = 1'b0;
`else
      m_ct_bits += 8 * eff_bytes(n);
`endif
    end else begin
      m_ct_bits += 8 * eff_bytes(n);
      m_in_ct = 1'b1;
    end
    if (fwd) begin
      exp_q.push_back('{model_mask(d, n), 1'b0});
      msg_beats.push_back(model_mask(d, n));
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
      check("in_ready_low_while_core_ready", 128'(ghash_ready), 128'd0);
      @(posedge clk); #1;
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL beat_accept_timeout: got in_ready 0 expected 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0; finish = 1'b0;
    if (fin) model_finish();
  endtask

  task automatic do_finish();
    finish = 1'b1;
    model_finish();
    @(posedge clk); #1 finish = 1'b0;
  endtask

  task automatic wait_done();
    bit got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) begin got = 1'b1; break; end
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL done_timeout: got done 0 expected 1");
    end
    @(posedge clk); #1;
    check("idle_after_done", 128'(busy), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
    in_data = '0; in_is_aad = 1'b0; in_bytes = '0; ghash_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    check("rst_s_out", s_out, 128'd0);
    check("rst_done", 128'(done), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_in_ready", 128'(in_ready), 128'd0);
    check("rst_ghash_valid", 128'(ghash_valid), 128'd0);
    check("rst_ghash_start", 128'(ghash_start), 128'd0);
    check("rst_err", 128'(err), 128'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;

    // empty message
    do_start();
    do_finish();
    wait_done();
    check("empty_len_lit", last_len, 128'd0);
    check("empty_s_lit", s_out, 128'd0);

    // one full AAD beat, one full CT beat (in_bytes=0 means 16)
    do_start();
    send_beat(128'h00112233_44556677_8899AABB_CCDDEEFF, 16, 1'b1, 1'b0);
    send_beat(128'hA5A5A5A5_5A5A5A5A_01234567_89ABCDEF, 0, 1'b0, 1'b0);
    do_finish();
    wait_done();
    check("full_len_lit", last_len, {64'd128, 64'd128});

    // 5-byte CT beat with finish in the same cycle
    do_start();
    send_beat({128{1'b1}}, 5, 1'b0, 1'b1);
    wait_done();
    check("partial_beat_lit", last_beat, 128'hFFFFFFFFFF000000_0000000000000000);
    check("partial_len_lit", last_len, {64'd0, 64'd40});

    // core stalls during AAD and LEN
    do_start();
    ghash_ready = 1'b0;
    fork begin repeat (3) @(posedge clk); #1 ghash_ready = 1'b1; end join_none
    send_beat(128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0, 20, 1'b1, 1'b0);
    ghash_ready = 1'b0;
    do_finish();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("len_stall_busy", 128'(busy), 128'd1);
      check("len_stall_no_done", 128'(done), 128'd0);
      @(posedge clk); #1;
    end
    ghash_ready = 1'b1;
    wait_done();
    check("stall_len_lit", last_len, {64'd128, 64'd0});

    // abort mid-CT, then a one-beat AAD message
    s_prev = s_out;
    do_start();
    send_beat(128'h11111111_22222222_33333333_44444444, 16, 1'b0, 1'b0);
    send_beat(128'h55555555_66666666_77777777_88888888, 16, 1'b0, 1'b0);
    do_start();
    check("abort_s_out_held", s_out, s_prev);
    send_beat(128'hDEADBEEF_CAFEF00D_01020304_05060708, 16, 1'b1, 1'b1);
    wait_done();
    check("abort_len_lit", last_len, {64'd128, 64'd0});

    // AAD beat after a CT beat
    do_start();
    send_beat(128'h99999999_88888888_77777777_66666666, 16, 1'b0, 1'b0);
    send_beat(128'h12345678_9ABCDEF0_0FEDCBA9_87654321, 8, 1'b1, 1'b0);
`ifdef GCM_GHASH_CTRL_ORDER_CHECK_EN
    check("order_err_set", 128'(err), 128'd1);
`else
    check("order_err_tied", 128'(err), 128'd0);
`endif
    do_finish();
    wait_done();
`ifdef GCM_GHASH_CTRL_ORDER_CHECK_EN
    check("order_len_lit", last_len, {64'd0, 64'd128});
    check("order_err_sticky", 128'(err), 128'd1);
`else
    check("order_len_lit", last_len, {64'd0, 64'd192});
`endif
    do_start();
    check("err_cleared", 128'(err), 128'd0);
    do_finish();
    wait_done();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gcm_ghash_ctrl.md
Name: gcm_ghash_ctrl

Overview:
- Sequencer in front of the GHASH accumulator core for AES-GCM.
- Accepts one message as a stream of 128-bit beats: AAD beats first, then ciphertext beats.
- Pads partial blocks, clears the core at message start, counts AAD and ciphertext bit lengths, and appends the final {len(A), len(C)} block.
- Captures the final GHASH value S and hands it to the tag stage.

Parameters:
- LEN_W, 39, width of each internal bit-length counter; each counter wraps modulo 2^LEN_W and is zero-extended into its 64-bit length field.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; begins a new message, aborting any message in progress
- finish  input  1  one-cycle pulse; no more beats for this message
- in_valid  input  1  beat valid
- in_ready  output  1  beat accepted when in_valid && in_ready
- in_data  input  128  beat data, byte 0 at bits [127:120]
- in_is_aad  input  1  1 = AAD beat, 0 = ciphertext beat
- in_bytes  input  5  valid bytes in beat, MSB-first; 1..16 literal, 0 or >16 means 16
- ghash_start  output  1  drives the core's start input
- ghash_data  output  128  drives the core's data_in
- ghash_valid  output  1  drives the core's data_valid
- ghash_ready  input  1  the core's ready
- ghash_hash  input  128  the core's hash_out
- s_out  output  128  final GHASH value, held until the next done
- done  output  1  one-cycle pulse when s_out is updated
- busy  output  1  high in every state except IDLE
- err  output  1  sticky ordering error, cleared by start (see Optional Feature)

Behaviour:
- Reset (async): state IDLE, both counters 0, s_out 0, done 0, err 0, ghash_start 0, ghash_valid 0, in_ready 0, busy 0.
- States: IDLE, CLR, AAD, CT, LEN, WAIT.
- IDLE:
  - start -> CLR.
  - finish and in_valid are ignored.
- CLR (1 cycle):
  - ghash_start=1, counters <= 0, err <= 0.
  - -> AAD.
- AAD:
  - in_ready = ghash_ready.
  - An accepted beat with in_is_aad=1 is forwarded in the same cycle: ghash_valid=1, ghash_data = in_data with bytes >= in_bytes forced to 0. AAD counter += 8*in_bytes (wraps).
  - An accepted beat with in_is_aad=0 is forwarded the same way, adds to the CT counter, and moves the state to CT.
- CT:
  - Same forwarding rules; ciphertext beats add to the CT counter.
  - An AAD beat in CT is an ordering error (see Optional Feature).
- finish in AAD/CT:
  - -> LEN.
  - If a beat is accepted in the same cycle, it is forwarded and counted first.
  - Empty AAD, empty CT, or both empty are legal.
- LEN:
  - in_ready=0.
  - ghash_data = {64-bit zero-extended AAD bit count, 64-bit zero-extended CT bit count}.
  - ghash_valid = ghash_ready; leave for WAIT on the cycle ghash_ready=1.
- WAIT (1 cycle):
  - The core has updated its accumulator.
  - s_out <= ghash_hash and done <= 1 (both visible the cycle after WAIT); -> IDLE.
- Latency: from the LEN beat edge, done asserts 2 cycles later.
- start in any non-IDLE state: abort and -> CLR; s_out is unchanged and no done is issued.
- start takes priority over finish and over any beat in the same cycle; that beat is not accepted (in_ready forced to 0).
- ghash_valid is never asserted outside AAD, CT and LEN.
- ghash_valid and ghash_start are never asserted together.

Optional Feature:
- Macro GCM_GHASH_CTRL_ORDER_CHECK_EN.
- Defined:
  - An AAD beat accepted in CT is consumed (in_ready=1) but not forwarded and not counted.
  - err <= 1 and stays set until the next CLR.
- Undefined:
  - err is tied to 0.
  - An AAD beat in CT is forwarded and counted as ciphertext.

Test Plan:
- Empty message: start, then finish 2 cycles later -> one ghash beat of 128'h0, then done with s_out = ghash_hash after that beat (0 when H·0).
- 1 full AAD beat, 1 full CT beat, finish -> three ghash beats; the last carries {64'd128, 64'd128}; done exactly 2 cycles after the length beat.
- CT beat in_data=128'hFFFF...FF, in_bytes=5 -> ghash_data=128'hFFFFFFFFFF00...00; length block {64'd0, 64'd40}.
- Hold ghash_ready=0 for 3 cycles during AAD and LEN -> no beat accepted and no ghash_valid while low; the sequence resumes unchanged.
- start mid-CT after 2 beats -> ghash_start pulse, counters 0, no done; a following 1-beat AAD message yields length {64'd128, 64'd0}.
- With GCM_GHASH_CTRL_ORDER_CHECK_EN defined: AAD beat after a CT beat -> err=1, no ghash_valid that cycle, CT length unchanged; err cleared by the next start.
